// File: rtl/shift_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// shift_ctrl_pkg
//   Shared definitions for the shift-register sequencer:
//     - state_t   : controller FSM state encoding
//     - SEL_*     : select codes understood by the n-bit shift register
//     - shift_sel : maps a direction bit onto the matching shift select code
// -----------------------------------------------------------------------------
package shift_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_SHIFT = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  // Select codes of the controlled shift register.
  localparam logic [1:0] SEL_SHL  = 2'b00;
  localparam logic [1:0] SEL_SHR  = 2'b01;
  localparam logic [1:0] SEL_LOAD = 2'b10;
  localparam logic [1:0] SEL_HOLD = 2'b11;

  // dir = 0 shifts toward the MSB, dir = 1 shifts toward the LSB.
  function automatic logic [1:0] shift_sel(input logic dir);
    return dir ? SEL_SHR : SEL_SHL;
  endfunction

endpackage

// File: rtl/shift_seq_cnt.sv
// -----------------------------------------------------------------------------
// shift_seq_cnt
//   Loadable CNT_W-bit down-counter holding the number of shift cycles still
//   to perform. Decrementing saturates at zero.
//
// Ports:
//   clk       in   rising-edge clock
//   rst       in   asynchronous active-high reset (counter clears to 0)
//   load      in   load load_val (takes priority over dec)
//   load_val  in   CNT_W  value to load
//   dec       in   decrement by one
//   zero      out  counter is 0
//   last      out  counter is 1 (the current cycle is the final shift)
// -----------------------------------------------------------------------------
module shift_seq_cnt #(
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  input  logic             dec,
  output logic             zero,
  output logic             last
);

  logic [CNT_W-1:0] value;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      value <= '0;
    end else if (load) begin
      value <= load_val;
    end else if (dec && (value != '0)) begin
      value <= value - 1'b1;
    end
  end

  assign zero = (value == '0);
  assign last = (value == CNT_W'(1));

endmodule

// File: rtl/shift_seq_ctrl.sv
// -----------------------------------------------------------------------------
// shift_seq_ctrl
//   Command-driven sequencer for an n-bit shift register. A command (load word,
//   direction, shift count) is accepted over cmd_valid/cmd_ready; the register
//   is then parallel-loaded for one cycle and shifted count times with zeros
//   shifting in. Each departing bit is presented on ser_out/ser_valid, and the
//   final register word is returned over res_valid/res_ready.
//
//   Timeline for count N, command accepted in cycle c0:
//     c1           LOAD   (sr_sel = 10, sr_din = word)
//     c2..c(1+N)   SHIFT  (sr_sel = 00/01, ser_valid = 1)
//     c(2+N)..     DONE   (sr_sel = 11, res_valid = 1 until res_ready)
//
// Ports:
//   clk, rst            clock, asynchronous active-high reset
//   cmd_valid/ready     command handshake
//   cmd_data [WIDTH]    word to parallel-load
//   cmd_dir             0 = shift left, 1 = shift right
//   cmd_count [CNT_W]   shift cycles after the load (0 allowed)
//   sr_sel [2], sr_din  drive the shift register
//   sr_dout [WIDTH]     current shift-register contents
//   ser_out, ser_valid  bit leaving the register this cycle
//   res_valid/ready     result handshake
//   res_data [WIDTH]    final register word
//   busy                high whenever the FSM is not idle
// -----------------------------------------------------------------------------
module shift_seq_ctrl
  import shift_ctrl_pkg::*;
#(
  parameter int WIDTH = 4,
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [WIDTH-1:0] cmd_data,
  input  logic             cmd_dir,
  input  logic [CNT_W-1:0] cmd_count,
  output logic [1:0]       sr_sel,
  output logic [WIDTH-1:0] sr_din,
  input  logic [WIDTH-1:0] sr_dout,
  output logic             ser_out,
  output logic             ser_valid,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [WIDTH-1:0] res_data,
  output logic             busy
);

  state_t           state_reg;
  logic             dir_reg;
  logic [WIDTH-1:0] data_reg;

  logic             cmd_accept;
  logic             res_accept;
  logic             cnt_zero;
  logic             cnt_last;

  assign cmd_accept = cmd_valid && cmd_ready;
  assign res_accept = res_valid && res_ready;

  // Remaining shift cycles. Loaded at acceptance so later cmd_count changes
  // are ignored; counts down once per SHIFT cycle.
  shift_seq_cnt #(
    .CNT_W (CNT_W)
  ) u_cnt (
    .clk      (clk),
    .rst      (rst),
    .load     (cmd_accept),
    .load_val (cmd_count),
    .dec      (state_reg == ST_SHIFT),
    .zero     (cnt_zero),
    .last     (cnt_last)
  );

  // Controller FSM. Handshake flags, select and busy are registered so they
  // change only on state transitions.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= ST_IDLE;
      dir_reg   <= 1'b0;
      data_reg  <= '0;
      cmd_ready <= 1'b1;
      sr_sel    <= SEL_HOLD;
      ser_valid <= 1'b0;
      res_valid <= 1'b0;
      busy      <= 1'b0;
    end else begin
      case (state_reg)
        ST_IDLE: begin
          if (cmd_accept) begin
            data_reg  <= cmd_data;
            dir_reg   <= cmd_dir;
            state_reg <= ST_LOAD;
            cmd_ready <= 1'b0;
            busy      <= 1'b1;
            sr_sel    <= SEL_LOAD;
          end
        end

        ST_LOAD: begin
          if (cnt_zero) begin
            state_reg <= ST_DONE;
            sr_sel    <= SEL_HOLD;
            res_valid <= 1'b1;
          end else begin
            state_reg <= ST_SHIFT;
            sr_sel    <= shift_sel(dir_reg);
            ser_valid <= 1'b1;
          end
        end

        ST_SHIFT: begin
          // The counter still shows the remaining cycles including this one,
          // so a value of 1 marks the final shift edge.
          if (cnt_last) begin
            state_reg <= ST_DONE;
            sr_sel    <= SEL_HOLD;
            ser_valid <= 1'b0;
            res_valid <= 1'b1;
          end
        end

        ST_DONE: begin
          // cmd_ready only rises on entering IDLE, so a command waiting here
          // is taken one cycle later -- no DONE-to-LOAD bypass.
          if (res_accept) begin
            state_reg <= ST_IDLE;
            res_valid <= 1'b0;
            busy      <= 1'b0;
            cmd_ready <= 1'b1;
          end
        end

        default: begin
          state_reg <= ST_IDLE;
          cmd_ready <= 1'b1;
          sr_sel    <= SEL_HOLD;
          ser_valid <= 1'b0;
          res_valid <= 1'b0;
          busy      <= 1'b0;
        end
      endcase
    end
  end

  // The load word is only presented while the register is told to load.
  assign sr_din = (state_reg == ST_LOAD) ? data_reg : '0;

  // The serial tap and the result word come straight from the register
  // contents: the departing bit is the one sitting at the outgoing end in the
  // current cycle, and the last shift edge coincides with entering DONE, so a
  // registered copy would lag by one cycle. In DONE the register holds, so
  // res_data is stable for the whole handshake.
  assign ser_out  = (state_reg == ST_SHIFT) &&
                    (dir_reg ? sr_dout[0] : sr_dout[WIDTH-1]);
  assign res_data = (state_reg == ST_DONE) ? sr_dout : '0;

  // Consistency of the registered status flags with the state.
  a_busy_state : assert property (@(posedge clk) disable iff (rst)
    busy == (state_reg != ST_IDLE));
  a_ready_state : assert property (@(posedge clk) disable iff (rst)
    cmd_ready == (state_reg == ST_IDLE));
  a_res_state : assert property (@(posedge clk) disable iff (rst)
    res_valid == (state_reg == ST_DONE));
  a_ser_state : assert property (@(posedge clk) disable iff (rst)
    ser_valid == (state_reg == ST_SHIFT));

endmodule
